// File: rtl/bcd_scan_decoder.sv
//------------------------------------------------------------------------------
// bcd_scan_decoder
//
// Multi-digit BCD-to-decimal scan decoder. A packed BCD word is captured on a
// load strobe and shown one digit at a time on a one-hot 10-line decimal bus.
// Each digit stays on the bus for DWELL clock cycles. A one-hot digit select
// and a binary digit index identify the digit currently shown.
//
// Parameters
//   DIGITS : number of BCD digits scanned (>= 1)
//   DWELL  : clock cycles each digit is displayed (>= 1)
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   en         : scan enable; when low the scan freezes and the decode
//                outputs (dec_out, dig_sel, invalid) clear to 0
//   load       : capture bcd_in on this edge (independent of en)
//   bcd_in     : packed BCD, nibble k = digit k, nibble 0 = least significant
//   dec_out    : one-hot decimal value of the displayed digit (bit n = value n)
//   dig_sel    : one-hot select of the displayed digit
//   dig_idx    : binary index of the displayed digit (holds while en=0)
//   invalid    : displayed nibble is a non-BCD code (10..15)
//   frame_done : one-cycle pulse when the last digit's dwell ends
//
// Optional build macro
//   BCD_LEADING_ZERO_BLANK_EN : when defined, a zero digit k>0 with all
//   higher digits also zero is blanked (dec_out=0). Digit 0 is never blanked.
//
// All outputs are registered from the current state, so they lag the scan
// state by exactly one clock.
//------------------------------------------------------------------------------
module bcd_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic                                   load,
    input  logic [4*DIGITS-1:0]                    bcd_in,
    output logic [9:0]                             dec_out,
    output logic [DIGITS-1:0]                      dig_sel,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] dig_idx,
    output logic                                   invalid,
    output logic                                   frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(DWELL - 1);

    //--------------------------------------------------------------------------
    // Scan state
    //--------------------------------------------------------------------------
    logic [4*DIGITS-1:0] snap_reg,  snap_next;
    logic [PRE_W-1:0]    presc_reg, presc_next;
    logic [IDX_W-1:0]    idx_reg,   idx_next;
    // Set on the edge where the last digit's dwell wraps; the pulse itself is
    // issued one edge later so it lines up with the delayed display outputs.
    logic                frame_pend_reg, frame_pend_next;

    //--------------------------------------------------------------------------
    // Registered outputs
    //--------------------------------------------------------------------------
    logic [9:0]          dec_reg,     dec_next;
    logic [DIGITS-1:0]   sel_reg,     sel_next;
    logic [IDX_W-1:0]    dig_idx_reg, dig_idx_next;
    logic                invalid_reg, invalid_next;
    logic                frame_done_reg, frame_done_next;

    //--------------------------------------------------------------------------
    // Digit extraction
    //--------------------------------------------------------------------------
    logic [3:0] nibbles [DIGITS];
    logic [3:0] cur_nib;
    logic       nib_invalid;
    logic       blank;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nibbles[gi] = snap_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_nib     = nibbles[idx_reg];
    assign nib_invalid = (cur_nib > 4'd9);

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // zero_from[k] is high when nibbles k..DIGITS-1 are all zero, i.e. digit k
    // is a leading zero. Digit 0 is excluded so a value of 0 still shows "0".
    logic [DIGITS:0] zero_from;
    logic            blank_at [DIGITS];

    assign zero_from[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
            assign zero_from[gi] = (nibbles[gi] == 4'd0) && zero_from[gi+1];
            if (gi == 0) begin : g_d0
                assign blank_at[gi] = 1'b0;
            end else begin : g_dk
                assign blank_at[gi] = zero_from[gi];
            end
        end
    endgenerate

    assign blank = blank_at[idx_reg];
`else
    assign blank = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Next scan state
    //--------------------------------------------------------------------------
    always_comb begin
        snap_next       = snap_reg;
        presc_next      = presc_reg;
        idx_next        = idx_reg;
        frame_pend_next = 1'b0;

        if (load) begin
            snap_next = bcd_in;
        end

        if (en) begin
            if (presc_reg == LAST_PRE) begin
                presc_next      = '0;
                idx_next        = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
                frame_pend_next = (idx_reg == LAST_IDX);
            end else begin
                presc_next = presc_reg + PRE_W'(1);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Next output values, decoded from the current state
    //--------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_dec
            assign dec_next[gi] = en && !nib_invalid && !blank &&
                                  (cur_nib == 4'(gi));
        end
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
            assign sel_next[gi] = en && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // dig_idx keeps the last shown index while paused; the other decode
    // outputs blank.
    assign dig_idx_next    = en ? idx_reg : dig_idx_reg;
    assign invalid_next    = en && nib_invalid;
    assign frame_done_next = en && frame_pend_reg;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_reg       <= '0;
            presc_reg      <= '0;
            idx_reg        <= '0;
            frame_pend_reg <= 1'b0;
            dec_reg        <= '0;
            sel_reg        <= '0;
            dig_idx_reg    <= '0;
            invalid_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            snap_reg       <= snap_next;
            presc_reg      <= presc_next;
            idx_reg        <= idx_next;
            frame_pend_reg <= frame_pend_next;
            dec_reg        <= dec_next;
            sel_reg        <= sel_next;
            dig_idx_reg    <= dig_idx_next;
            invalid_reg    <= invalid_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign dec_out    = dec_reg;
    assign dig_sel    = sel_reg;
    assign dig_idx    = dig_idx_reg;
    assign invalid    = invalid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
//------------------------------------------------------------------------------
// Testbench for bcd_scan_decoder (DIGITS=4, DWELL=3).
// The reference model tracks the scan as a single position 0..DIGITS*DWELL-1
// and derives digit values from the snapshot with shifts and masks.
//------------------------------------------------------------------------------
module tb_bcd_scan_decoder;

    localparam int DIGITS = 4;
    localparam int DWELL  = 3;
    localparam int FRAME  = DIGITS * DWELL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [9:0]  dec_out;
    logic [3:0]  dig_sel;
    logic [1:0]  dig_idx;
    logic        invalid;
    logic        frame_done;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state
    logic [15:0] m_snap = '0;
    int          m_pos  = 0;
    bit          m_pend = 1'b0;
    logic [9:0]  m_dec  = '0;
    logic [3:0]  m_sel  = '0;
    logic [1:0]  m_idx  = '0;
    logic        m_inv  = 1'b0;
    logic        m_fd   = 1'b0;

    bcd_scan_decoder #(.DIGITS(DIGITS), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dec_out    (dec_out),
        .dig_sel    (dig_sel),
        .dig_idx    (dig_idx),
        .invalid    (invalid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_dec(input logic [15:0] s, input int k);
        int d;
        d = int'((s >> (4 * k)) & 16'hF);
        if (d > 9) return 10'h000;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (k > 0 && (s >> (4 * k)) == 16'h0) return 10'h000;
`endif
        return 10'h001 << d;
    endfunction

    // One clock: drive inputs at negedge, advance the model at posedge,
    // settle 1 time unit, then the caller compares.
    task automatic step(input logic r, input logic e, input logic l, input logic [15:0] b);
        int k;
        int d;
        @(negedge clk);
        rst_n = r; en = e; load = l; bcd_in = b;
        @(posedge clk);
        if (!r) begin
            m_snap = '0; m_pos = 0; m_pend = 1'b0;
            m_dec = '0; m_sel = '0; m_idx = '0; m_inv = 1'b0; m_fd = 1'b0;
        end else begin
            k = m_pos / DWELL;
            d = int'((m_snap >> (4 * k)) & 16'hF);
            if (e) begin
                m_dec = exp_dec(m_snap, k);
                m_sel = 4'(1 << k);
                m_idx = 2'(k);
                m_inv = (d > 9);
            end else begin
                m_dec = '0; m_sel = '0; m_inv = 1'b0;
            end
            m_fd   = m_pend && e;
            m_pend = e && (m_pos == FRAME - 1);
            if (e) m_pos = (m_pos + 1) % FRAME;
            if (l) m_snap = b;
        end
        #1;
        cyc++;
        $display("cyc %0d rst_n=%b en=%b load=%b bcd_in=%h | dec=%h sel=%b idx=%0d inv=%b fd=%b",
                 cyc, r, e, l, b, dec_out, dig_sel, dig_idx, invalid, frame_done);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            vectors++;
            if ({dec_out, dig_sel, dig_idx, invalid, frame_done} !== 18'h0) begin
                errors++;
                $display("FAIL reset: got dec=%h sel=%b idx=%0d inv=%b fd=%b, expected all 0",
                         dec_out, dig_sel, dig_idx, invalid, frame_done);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [9:0] tbl [4];
        tbl[0] = 10'h080; tbl[1] = 10'h010; tbl[2] = 10'h200; tbl[3] = 10'h002;
        step(1'b1, 1'b0, 1'b1, 16'h1947);
        for (int c = 0; c <= FRAME; c++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            vectors++;
            if (c < FRAME && (dec_out !== tbl[c / DWELL] || dig_sel !== 4'(1 << (c / DWELL)) ||
                              dig_idx !== 2'(c / DWELL) || invalid !== 1'b0)) begin
                errors++;
                $display("FAIL basic_scan c=%0d: got dec=%h sel=%b idx=%0d inv=%b, expected dec=%h sel=%b idx=%0d inv=0",
                         c, dec_out, dig_sel, dig_idx, invalid, tbl[c / DWELL], 4'(1 << (c / DWELL)), c / DWELL);
            end
            vectors++;
            if (frame_done !== (c == FRAME)) begin
                errors++;
                $display("FAIL basic_frame_done c=%0d: got %b expected %b", c, frame_done, c == FRAME);
            end
        end
    endtask

    task automatic test_invalid();
        step(1'b1, 1'b1, 1'b1, 16'h00A5);
        for (int c = 0; c < FRAME; c++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            vectors++;
            if ({dec_out, dig_sel, dig_idx, invalid, frame_done} !== {m_dec, m_sel, m_idx, m_inv, m_fd}) begin
                errors++;
                $display("FAIL invalid_model c=%0d: got dec=%h sel=%b idx=%0d inv=%b fd=%b, expected dec=%h sel=%b idx=%0d inv=%b fd=%b",
                         c, dec_out, dig_sel, dig_idx, invalid, frame_done, m_dec, m_sel, m_idx, m_inv, m_fd);
            end
            if (dig_idx == 2'd1) begin
                vectors++;
                if (dec_out !== 10'h0 || invalid !== 1'b1 || dig_sel !== 4'b0010) begin
                    errors++;
                    $display("FAIL invalid_digit1: got dec=%h inv=%b sel=%b, expected dec=000 inv=1 sel=0010",
                             dec_out, invalid, dig_sel);
                end
            end
            if (dig_idx == 2'd0) begin
                vectors++;
                if (dec_out !== 10'h020 || invalid !== 1'b0 || dig_sel !== 4'b0001) begin
                    errors++;
                    $display("FAIL invalid_digit0: got dec=%h inv=%b sel=%b, expected dec=020 inv=0 sel=0001",
                             dec_out, invalid, dig_sel);
                end
            end
        end
    endtask

    task automatic test_pause();
        int pos_before;
        logic [1:0] idx_before;
        step(1'b1, 1'b1, 1'b1, 16'h3210);
        while (m_pos != 4) step(1'b1, 1'b1, 1'b0, 16'h0);
        pos_before = m_pos;
        idx_before = dig_idx;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            vectors++;
            if (dec_out !== 10'h0 || dig_sel !== 4'h0 || invalid !== 1'b0 ||
                frame_done !== 1'b0 || dig_idx !== idx_before) begin
                errors++;
                $display("FAIL pause i=%0d: got dec=%h sel=%b inv=%b fd=%b idx=%0d, expected 0/0/0/0 idx=%0d",
                         i, dec_out, dig_sel, invalid, frame_done, dig_idx, idx_before);
            end
        end
        for (int c = 0; c < FRAME + 2; c++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            vectors++;
            if ({dec_out, dig_sel, dig_idx, invalid, frame_done} !== {m_dec, m_sel, m_idx, m_inv, m_fd}) begin
                errors++;
                $display("FAIL pause_resume c=%0d (pos at pause %0d): got dec=%h sel=%b idx=%0d inv=%b fd=%b, expected dec=%h sel=%b idx=%0d inv=%b fd=%b",
                         c, pos_before, dec_out, dig_sel, dig_idx, invalid, frame_done, m_dec, m_sel, m_idx, m_inv, m_fd);
            end
        end
    endtask

    task automatic test_midload();
        step(1'b1, 1'b1, 1'b1, 16'h1234);
        while (m_pos != 2 * DWELL) step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h8888);
        for (int c = 0; c < 2 * DWELL - 1; c++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            vectors++;
            if (dec_out !== 10'h100 || dig_idx !== 2'(2 + (c + 1) / DWELL)) begin
                errors++;
                $display("FAIL midload c=%0d: got dec=%h idx=%0d, expected dec=100 idx=%0d",
                         c, dec_out, dig_idx, 2 + (c + 1) / DWELL);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b1, 16'h5678);
        while (m_pos != 3 * DWELL + 1) step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        vectors++;
        if ({dec_out, dig_sel, dig_idx, invalid, frame_done} !== 18'h0) begin
            errors++;
            $display("FAIL reset_mid: got dec=%h sel=%b idx=%0d inv=%b fd=%b, expected all 0",
                     dec_out, dig_sel, dig_idx, invalid, frame_done);
        end
        step(1'b1, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (dec_out !== 10'h001 || dig_sel !== 4'b0001 || dig_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_restart: got dec=%h sel=%b idx=%0d, expected dec=001 sel=0001 idx=0",
                     dec_out, dig_sel, dig_idx);
        end
    endtask

    task automatic test_leading_zero();
        logic [9:0] tbl [4];
        tbl[0] = 10'h001; tbl[1] = 10'h010;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        tbl[2] = 10'h000; tbl[3] = 10'h000;
`else
        tbl[2] = 10'h001; tbl[3] = 10'h001;
`endif
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 16'h0040);
        for (int c = 0; c < FRAME; c++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            vectors++;
            if (dec_out !== tbl[c / DWELL] || dig_sel !== 4'(1 << (c / DWELL)) || invalid !== 1'b0) begin
                errors++;
                $display("FAIL leading_zero c=%0d: got dec=%h sel=%b inv=%b, expected dec=%h sel=%b inv=0",
                         c, dec_out, dig_sel, invalid, tbl[c / DWELL], 4'(1 << (c / DWELL)));
            end
        end
    endtask

    task automatic test_random();
        logic r, e, l;
        logic [15:0] b;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) >= 2);
            e = ($urandom_range(0, 99) < 80);
            l = ($urandom_range(0, 99) < 15);
            b = 16'($urandom) >> (4 * $urandom_range(0, 3));
            step(r, e, l, b);
            vectors++;
            if ({dec_out, dig_sel, dig_idx, invalid, frame_done} !== {m_dec, m_sel, m_idx, m_inv, m_fd}) begin
                errors++;
                $display("FAIL random i=%0d: got dec=%h sel=%b idx=%0d inv=%b fd=%b, expected dec=%h sel=%b idx=%0d inv=%b fd=%b",
                         i, dec_out, dig_sel, dig_idx, invalid, frame_done, m_dec, m_sel, m_idx, m_inv, m_fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_invalid();
        test_pause();
        test_midload();
        test_reset_mid();
        test_leading_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
